// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: serialiser state encoding,
// parity mode constants and the frame parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Parity over the low nbits of data; the odd mode returns the inverse.
    function automatic logic frame_parity(input logic [7:0] data,
                                          input int unsigned nbits,
                                          input int unsigned mode);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nbits) p ^= data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, synchronous flush and
// un-reset storage. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_LEVEL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO: configurable data bits, parity and
// stop bits, back-to-back frames while data is queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_flush,
    output logic                   o_uart_tx,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned BAUD_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bits_check
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2) begin : g_frame_check
        $error("uart_tx_fifo: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    uart_state_e       state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              par_bit, par_n;
    logic              tx_q, tx_n;
    logic              line_active;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic              bit_end;
    logic              can_pop;
    logic              head_parity;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (i_valid),
        .pop    (fifo_pop),
        .flush  (i_flush),
        .wdata  (i_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (o_level)
    );

    assign o_ready     = !fifo_full;
    assign o_uart_tx   = tx_q;
    // line_active covers the final stop-bit cycle, which tx_q shows one clock after the state.
    assign o_busy      = (state != ST_IDLE) || !fifo_empty || line_active;
    assign bit_end     = (baud_cnt == '0);
    assign can_pop     = !fifo_empty && !i_flush;
    assign head_parity = frame_parity(fifo_rdata, DATA_BITS, PARITY);

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        par_n    = par_bit;
        fifo_pop = 1'b0;
        tx_n     = 1'b1;
        case (state)
            ST_IDLE: begin
                if (can_pop) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_rdata;
                    par_n    = head_parity;
                    baud_n   = BAUD_RELOAD;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    baud_n  = BAUD_RELOAD;
                    bit_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                tx_n = shreg[0];
                if (bit_end) begin
                    baud_n  = BAUD_RELOAD;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            ST_PARITY: begin
                tx_n = par_bit;
                if (bit_end) begin
                    baud_n  = BAUD_RELOAD;
                    bit_n   = '0;
                    state_n = ST_STOP;
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == LAST_STOP) begin
                        if (can_pop) begin
                            fifo_pop = 1'b1;
                            shreg_n  = fifo_rdata;
                            par_n    = head_parity;
                            baud_n   = BAUD_RELOAD;
                            state_n  = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bit_n  = bit_cnt + 1'b1;
                        baud_n = BAUD_RELOAD;
                    end
                end else begin
                    baud_n = baud_cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tx_q        <= 1'b1;
            line_active <= 1'b0;
        end else begin
            state       <= state_n;
            baud_cnt    <= baud_n;
            bit_cnt     <= bit_n;
            shreg       <= shreg_n;
            par_bit     <= par_n;
            tx_q        <= tx_n;
            line_active <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 7N2)
// at DIV=4, DEPTH=4; a line monitor decodes frames against queued expectations.
module tb_uart_tx_fifo;

    localparam int DIV = 4;

    typedef struct {
        logic [11:0] bits;
        int          len;
        bit          b2b;
        bit          abort;
    } frame_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] data  [4];
    logic       valid [4];
    logic       flush [4];
    logic       ready [4];
    logic       tx    [4];
    logic       busy  [4];
    logic [2:0] level [4];
    logic       line;
    int         sel = 0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    frame_t     exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign line = tx[sel];

    uart_tx_fifo #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .DEPTH(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .resetn(resetn), .i_data(data[0]), .i_valid(valid[0]), .o_ready(ready[0]),
           .i_flush(flush[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_level(level[0]));
    uart_tx_fifo #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .DEPTH(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_8e1 (.clk(clk), .resetn(resetn), .i_data(data[1]), .i_valid(valid[1]), .o_ready(ready[1]),
           .i_flush(flush[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_level(level[1]));
    uart_tx_fifo #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .DEPTH(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8o1 (.clk(clk), .resetn(resetn), .i_data(data[2]), .i_valid(valid[2]), .o_ready(ready[2]),
           .i_flush(flush[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_level(level[2]));
    uart_tx_fifo #(.CLK_FREQ_HZ(400), .BAUD_RATE(100), .DEPTH(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .resetn(resetn), .i_data(data[3]), .i_valid(valid[3]), .o_ready(ready[3]),
           .i_flush(flush[3]), .o_uart_tx(tx[3]), .o_busy(busy[3]), .o_level(level[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [11:0] bits, input int len, input bit b2b, input bit abort);
        frame_t f;
        f.bits  = bits;
        f.len   = len;
        f.b2b   = b2b;
        f.abort = abort;
        exp_q.push_back(f);
    endtask

    task automatic write1(input int s, input logic [7:0] d);
        data[s]  = d;
        valid[s] = 1'b1;
        @(negedge clk);
        valid[s] = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int i;
        for (i = 0; i < limit && (exp_q.size() != 0 || busy[sel]); i++) @(negedge clk);
        check("drain_within_budget", (i < limit), 1);
        repeat (2 * DIV) @(negedge clk);
    endtask

    // Line monitor: samples every cycle of every bit on the falling edge.
    initial begin : monitor
        frame_t      e;
        logic [11:0] got;
        bit          held;
        bit          aborted;
        int          start_c;
        int          next_free;
        next_free = -1;
        forever begin
            @(negedge clk);
            if (resetn && line === 1'b0) begin
                start_c = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    repeat (12 * DIV) @(negedge clk);
                end else begin
                    e = exp_q[0];
                    got = '0;
                    held = 1'b1;
                    aborted = 1'b0;
                    for (int i = 0; i < e.len * DIV && !aborted; i++) begin
                        if (i != 0) @(negedge clk);
                        if (!resetn) aborted = 1'b1;
                        else if (i % DIV == 0) got[i / DIV] = line;
                        else if (line !== got[i / DIV]) held = 1'b0;
                    end
                    void'(exp_q.pop_front());
                    if (e.abort) begin
                        check("frame_aborted_by_reset", aborted, 1);
                    end else begin
                        check("frame_not_aborted", aborted, 0);
                        check("frame_bits", got, e.bits);
                        check("bit_hold_div_cycles", held, 1);
                        if (e.b2b) check("no_idle_gap", start_c, next_free);
                    end
                    next_free = start_c + e.len * DIV;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : stimulus
        int nb;
        logic [7:0] full_bytes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        int         full_lvl   [6] = '{1, 1, 2, 3, 4, 4};
        int         full_rdy   [6] = '{1, 1, 1, 1, 0, 0};
        logic [7:0] fl_bytes   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int         fl_lvl     [4] = '{1, 1, 2, 3};
        logic [7:0] rs_bytes   [3] = '{8'h0A, 8'h0B, 8'h0C};
        int         rs_lvl     [3] = '{1, 1, 2};

        for (int k = 0; k < 4; k++) begin
            data[k]  = 8'h00;
            valid[k] = 1'b0;
            flush[k] = 1'b0;
        end
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("reset_tx", tx[k], 1);
            check("reset_level", level[k], 0);
            check("reset_ready", ready[k], 1);
            check("reset_busy", busy[k], 0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 0x55: latency and busy window
        sel = 0;
        push_exp({1'b1, 8'h55, 1'b0}, 10, 1'b0, 1'b0);
        write1(0, 8'h55);
        check("level_after_write", level[0], 1);
        check("busy_after_write", busy[0], 1);
        check("tx_idle_edge_n", tx[0], 1);
        @(negedge clk);
        check("tx_idle_edge_n1", tx[0], 1);
        check("level_after_pop", level[0], 0);
        check("busy_edge_n1", busy[0], 1);
        @(negedge clk);
        check("tx_start_edge_n2", tx[0], 0);
        check("busy_edge_n2", busy[0], 1);
        nb = 3;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy[0]) break;
            nb++;
        end
        check("busy_cycles_8n1", nb, 42);
        wait_drain(300);

        // 8E1 / 8O1, 0x07: parity 1 / 0
        sel = 1;
        push_exp({1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        write1(1, 8'h07);
        wait_drain(300);
        sel = 2;
        push_exp({1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        write1(2, 8'h07);
        wait_drain(300);

        // 7N2, 0xFF: seven ones, two stop bits
        sel = 3;
        push_exp({2'b11, 7'h7F, 1'b0}, 10, 1'b0, 1'b0);
        write1(3, 8'hFF);
        wait_drain(300);

        // Full FIFO: 0x06 refused, 0x01..0x05 back to back
        sel = 0;
        push_exp({1'b1, 8'h01, 1'b0}, 10, 1'b0, 1'b0);
        push_exp({1'b1, 8'h02, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h03, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h04, 1'b0}, 10, 1'b1, 1'b0);
        push_exp({1'b1, 8'h05, 1'b0}, 10, 1'b1, 1'b0);
        valid[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data[0] = full_bytes[k];
            @(negedge clk);
            check("full_level", level[0], full_lvl[k]);
            check("full_ready", ready[0], full_rdy[k]);
        end
        valid[0] = 1'b0;
        wait_drain(1000);

        // Flush mid-frame on 8E1: 0x11 completes, queued bytes and same-cycle write dropped
        sel = 1;
        push_exp({1'b1, 1'b0, 8'h11, 1'b0}, 11, 1'b0, 1'b0);
        valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data[1] = fl_bytes[k];
            @(negedge clk);
            check("flush_fill_level", level[1], fl_lvl[k]);
        end
        valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("flush_precondition_busy", busy[1], 1);
        flush[1] = 1'b1;
        data[1]  = 8'h55;
        valid[1] = 1'b1;
        @(negedge clk);
        flush[1] = 1'b0;
        valid[1] = 1'b0;
        check("flush_level", level[1], 0);
        check("flush_ready", ready[1], 1);
        check("flush_frame_continues", busy[1], 1);
        wait_drain(500);
        repeat (100) @(negedge clk);
        check("flush_then_idle_busy", busy[1], 0);
        check("flush_then_idle_tx", tx[1], 1);

        // Reset in DATA on 7N2 with two bytes queued
        sel = 3;
        push_exp(12'h000, 10, 1'b0, 1'b1);
        valid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data[3] = rs_bytes[k];
            @(negedge clk);
            check("reset_fill_level", level[3], rs_lvl[k]);
        end
        valid[3] = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_precondition_tx_low", tx[3], 0);
        resetn = 1'b0;
        #1;
        check("reset_tx_immediate", tx[3], 1);
        check("reset_level_immediate", level[3], 0);
        check("reset_busy_immediate", busy[3], 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (150) @(negedge clk);
        check("after_reset_tx", tx[3], 1);
        check("after_reset_busy", busy[3], 0);
        check("after_reset_level", level[3], 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload bits per frame; range 5..8.
REQ-005 SHALL have parameter PARITY, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits per frame; 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port resetn, input, 1 bit; reset is asynchronous and active-low.
REQ-009 SHALL have port i_data, input, 8 bits, byte to enqueue.
REQ-010 SHALL have port i_valid, input, 1 bit, write request.
REQ-011 SHALL have port o_ready, input-side output, 1 bit, high when the FIFO is not full.
REQ-012 SHALL have port i_flush, input, 1 bit, synchronous FIFO clear.
REQ-013 SHALL have port o_uart_tx, output, 1 bit, serial line; idles high.
REQ-014 SHALL have port o_busy, output, 1 bit, high while a frame is on the line or the FIFO is non-empty.
REQ-015 SHALL have port o_level, output, $clog2(DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-016 SHALL accept a byte on a rising clk edge where i_valid and o_ready are both high; the byte is ignored when o_ready is low.
REQ-017 SHALL evaluate o_ready from the registered FIFO state only; a pop in the same cycle SHALL NOT make a full FIFO accept a write.
REQ-018 SHALL derive DIV = CLK_FREQ_HZ/BAUD_RATE (integer); elaboration SHALL fail if DIV < 2.
REQ-019 SHALL hold each line bit for exactly DIV clk cycles, using a counter reloaded with DIV-1 at every bit boundary.
REQ-020 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-021 IDLE: o_uart_tx=1; if the FIFO is non-empty, the block SHALL pop the head into the shift register and transition to START.
REQ-022 START: o_uart_tx=0 for one bit period, then transition to DATA.
REQ-023 DATA: the block SHALL send i_data[0..DATA_BITS-1] LSB first; unused upper bits are ignored; after DATA_BITS bits it SHALL transition to PARITY if PARITY≠0, otherwise to STOP.
REQ-024 PARITY: for even parity, the bit SHALL be the XOR of the sent bits; for odd parity, its inverse; duration is one bit period.
REQ-025 STOP: o_uart_tx=1 for STOP_BITS bit periods; then, if the FIFO is non-empty, the block SHALL pop and enter START directly (no idle gap), otherwise enter IDLE.
REQ-026 Latency: a write accepted at edge N into an empty FIFO while in IDLE SHALL drive o_uart_tx low from edge N+2.
REQ-027 Frame length SHALL be DIV*(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; o_level SHALL equal writes minus pops, in the range 0..DEPTH.
REQ-029 A simultaneous write and pop on a non-full, non-empty FIFO SHALL leave o_level unchanged.
REQ-030 i_flush SHALL zero the pointers and o_level at the next edge, SHALL win over a same-cycle write, and SHALL NOT abort a frame already in progress.
REQ-031 o_uart_tx SHALL be driven from a flop (glitch-free).

Reset
REQ-032 While resetn is low, the block SHALL set: state=IDLE, o_uart_tx=1, o_level=0, o_ready=1, o_busy=0, and baud counter=0.
REQ-033 Reset asserted mid-frame SHALL drive the line high immediately, discard the frame and the FIFO contents.
REQ-034 FIFO storage array SHALL not be reset.

Structure
REQ-035 Shared package uart_pkg SHALL hold the state encoding and the parity constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-036 The FIFO SHALL be a sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level, flush); the serialiser stays in uart_tx_fifo.

Verification (CLK_FREQ_HZ=400, BAUD_RATE=100 → DIV=4, DEPTH=4)
REQ-037 8N1 test: write 0x55 → after a 4-cycle low start bit, o_uart_tx SHALL show 1,0,1,0,1,0,1,0 for 4 cycles each, then 4 cycles high; o_busy SHALL be high for 42 cycles from the write.
REQ-038 8E1/8O1 test: 0x07 → parity bit SHALL be 1 (even) and 0 (odd); frame length SHALL be 44 cycles.
REQ-039 Full test: write 0x01, then 5 back-to-back writes 0x02..0x06 while busy → 0x06 SHALL be refused (o_ready=0, o_level=4); line SHALL emit 0x01..0x05 with no idle gap between frames.
REQ-040 7N2 test: write 0xFF → 7 data ones, no parity, 8 cycles of stop, frame length 40 cycles.
REQ-041 Reset/flush test: resetn low in the DATA state with 2 queued bytes → o_uart_tx=1 the same cycle, o_level=0, no further frames; separately, i_flush with 3 queued bytes while mid-frame → current frame completes, then IDLE.
